// File: rtl/exibe_pkg.sv
// State codes shared by the sequence presenter and its debug display.
package exibe_pkg;
  localparam int ESTADO_W = 4;

  localparam logic [ESTADO_W-1:0] OCIOSO  = 4'd0;
  localparam logic [ESTADO_W-1:0] CARREGA = 4'd1;
  localparam logic [ESTADO_W-1:0] ACENDE  = 4'd2;
  localparam logic [ESTADO_W-1:0] APAGA   = 4'd3;
  localparam logic [ESTADO_W-1:0] PROXIMO = 4'd4;
  localparam logic [ESTADO_W-1:0] FIM     = 4'd5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/exibe_sequencia_contador_tempo.sv
// Up-counter for the lit/dark intervals; fim flags that the count reached the
// compare value chosen by the FSM, so the counter itself never wraps.
module contador_tempo #(
  parameter int MAX = 1000,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] alvo,
  output logic         fim
);
  logic [W-1:0] r_cont;

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      r_cont <= '0;
    end else if (conta) begin
      r_cont <= r_cont + W'(1);
    end
  end

  assign fim = (r_cont == alvo);
endmodule

// File: rtl/exibe_sequencia.sv
// Presents the stored move sequence on the LEDs, address 0 up to limite.
// Optional `SEQ_PAUSA_EN adds a pausa input that freezes the lit/dark timing.
module exibe_sequencia
  import exibe_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 4,
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
`ifdef SEQ_PAUSA_EN
  input  logic                pausa,
`endif
  input  logic [ADDR_W-1:0]   limite,
  output logic [ADDR_W-1:0]   mem_endereco,
  input  logic [DATA_W-1:0]   mem_dado,
  output logic [DATA_W-1:0]   leds,
  output logic                exibindo,
  output logic                pronto,
  output logic [ESTADO_W-1:0] db_estado
);
  localparam int TMAX = max_int(ON_CYCLES, OFF_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  logic [ESTADO_W-1:0] r_estado;
  logic [ADDR_W-1:0]   r_endereco;
  logic [ADDR_W-1:0]   r_lim;
  logic [DATA_W-1:0]   r_dado;

  logic          w_pausa;
  logic          w_temporiza;
  logic          w_fim;
  logic          w_zera;
  logic          w_conta;
  logic [TW-1:0] w_alvo;

`ifdef SEQ_PAUSA_EN
  assign w_pausa = pausa;
`else
  assign w_pausa = 1'b0;
`endif

  // Timer only advances in the lit/dark states, and holds while paused.
  assign w_temporiza = ((r_estado == ACENDE) || (r_estado == APAGA)) && !w_pausa;
  assign w_alvo      = (r_estado == ACENDE) ? TW'(ON_CYCLES - 1) : TW'(OFF_CYCLES - 1);
  assign w_zera      = (r_estado == CARREGA) || (w_temporiza && w_fim);
  assign w_conta     = w_temporiza && !w_fim;

  contador_tempo #(
    .MAX (TMAX),
    .W   (TW)
  ) u_contador (
    .clock (clock),
    .reset (reset),
    .zera  (w_zera),
    .conta (w_conta),
    .alvo  (w_alvo),
    .fim   (w_fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_endereco <= '0;
      r_lim      <= '0;
      r_dado     <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (iniciar) begin
            r_lim      <= limite;
            r_endereco <= '0;
            r_estado   <= CARREGA;
          end
        end
        CARREGA: begin
          r_dado   <= mem_dado;
          r_estado <= ACENDE;
        end
        ACENDE: begin
          if (w_temporiza && w_fim) r_estado <= APAGA;
        end
        APAGA: begin
          // Stop on the last address so the increment never runs past lim.
          if (w_temporiza && w_fim) begin
            r_estado <= (r_endereco == r_lim) ? FIM : PROXIMO;
          end
        end
        PROXIMO: begin
          r_endereco <= r_endereco + ADDR_W'(1);
          r_estado   <= CARREGA;
        end
        FIM: begin
          r_endereco <= '0;
          r_estado   <= OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign mem_endereco = r_endereco;
  assign leds         = (r_estado == ACENDE) ? r_dado : '0;
  assign exibindo     = (r_estado == CARREGA) || (r_estado == ACENDE) ||
                        (r_estado == APAGA)   || (r_estado == PROXIMO);
  assign pronto       = (r_estado == FIM);
  assign db_estado    = r_estado;
endmodule
